// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the EX-stage multiply/divide unit.
// Contents: datapath width, mul/div op encodings, signed-select bit index,
// and the mul/div FSM state type.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  // op[1:0] encodings; op[1] set means a divide-class operation.
  localparam logic [1:0] MD_MUL  = 2'b00;
  localparam logic [1:0] MD_MULH = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] MD_REM  = 2'b11;

  // Bit of op that requests signed arithmetic.
  localparam int unsigned MD_SIGNED = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Bundle between the ID/EX / EX/MEM pipeline and the mul/div unit.
// slave  : the mul/div unit (consumes ID/EX fields, drives stall and result).
// master : the pipeline side.
// Signals: start_i, op_i[2:0], rs_data_i, rt_data_i, rd_addr_i, flush_i (to unit);
//          stall_o, done_o, result_o, rd_addr_o, reg_write_o (from unit).
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs_data_i;
  logic [XLEN-1:0] rt_data_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;
  logic            reg_write_o;

  modport slave (
    input  start_i, op_i, rs_data_i, rt_data_i, rd_addr_i, flush_i,
    output stall_o, done_o, result_o, rd_addr_o, reg_write_o
  );

  modport master (
    output start_i, op_i, rs_data_i, rt_data_i, rd_addr_i, flush_i,
    input  stall_o, done_o, result_o, rd_addr_o, reg_write_o
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the mul/div datapath.
// acc      : {hi, lo} working register. Multiply: {partial product, multiplier}.
//            Divide: {partial remainder, dividend/quotient}.
// operand  : multiplicand or divisor.
// is_div   : 1 selects restoring shift-subtract, 0 selects add-shift.
// acc_next : register value after this iteration.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   partial;
  logic [XLEN+1:0] diff;
  logic            unused_bits;

  always_comb begin
    // Multiply: add multiplicand when the current multiplier bit is set, then shift right.
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: remainder shifted left with the next dividend bit.
    partial = acc[2*XLEN-1:XLEN-1];
    diff    = {1'b0, partial} - {2'b00, operand};
    if (is_div) begin
      // Borrow out means the trial subtract failed: restore and shift in a 0.
      if (diff[XLEN+1]) begin
        acc_next = {partial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

  // Remainder never exceeds XLEN bits after a successful step.
  assign unused_bits = partial[XLEN] ^ diff[XLEN];

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit. Launches from ID/EX, stalls IF/ID
// and ID/EX while running, then presents result and destination for one cycle.
// Ports: clk_i, rst_i (async, active-low), md (ex_muldiv_unit_if.slave).
// Optional: define MULDIV_SIGNED_EN to honour op_i[2] (signed arithmetic);
// otherwise every operation is unsigned.
module ex_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ex_muldiv_unit_if.slave    md
);
  import pipe_pkg::*;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
  logic [XLEN-1:0]   operand_q, operand_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic [XLEN-1:0]   a_launch, b_launch;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_result;
  logic              stall, done;

`ifdef MULDIV_SIGNED_EN
  logic neg_q, neg_d;          // negate product / quotient at completion
  logic neg_rem_q, neg_rem_d;  // remainder follows dividend sign
  logic a_neg, b_neg;

  assign a_neg    = md.op_i[MD_SIGNED] & md.rs_data_i[XLEN-1];
  assign b_neg    = md.op_i[MD_SIGNED] & md.rt_data_i[XLEN-1];
  assign a_launch = a_neg ? (~md.rs_data_i + 1'b1) : md.rs_data_i;
  assign b_launch = b_neg ? (~md.rt_data_i + 1'b1) : md.rt_data_i;
  // Divide by zero keeps the unsigned all-ones quotient regardless of signs.
  assign neg_d     = (a_neg ^ b_neg) & ~(md.op_i[1] & (md.rt_data_i == '0));
  assign neg_rem_d = a_neg;
  assign prod_fix  = neg_q ? (~acc_step + 1'b1) : acc_step;
  assign quo_fix   = neg_q ? (~acc_step[XLEN-1:0] + 1'b1) : acc_step[XLEN-1:0];
  assign rem_fix   = neg_rem_q ? (~acc_step[2*XLEN-1:XLEN] + 1'b1) : acc_step[2*XLEN-1:XLEN];
`else
  logic unused_sign;

  assign unused_sign = md.op_i[MD_SIGNED];
  assign a_launch    = md.rs_data_i;
  assign b_launch    = md.rt_data_i;
  assign prod_fix    = acc_step;
  assign quo_fix     = acc_step[XLEN-1:0];
  assign rem_fix     = acc_step[2*XLEN-1:XLEN];
`endif

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .acc      (acc_q),
    .operand  (operand_q),
    .is_div   (op_q[1]),
    .acc_next (acc_step)
  );

  always_comb begin
    final_result = '0;
    unique case (op_q)
      MD_MUL:  final_result = prod_fix[XLEN-1:0];
      MD_MULH: final_result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV:  final_result = quo_fix;
      MD_REM:  final_result = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    op_d      = op_q;
    rd_d      = rd_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    stall     = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Gated by reset so stall reads 0 while the unit is held in reset.
        stall = md.start_i & ~md.flush_i & rst_i;
        if (stall) begin
          // Multiply and divide both start with {0, A}.
          acc_d     = {{XLEN{1'b0}}, a_launch};
          operand_d = b_launch;
          op_d      = md.op_i[1:0];
          rd_d      = md.rd_addr_i;
          cnt_d     = CNT_W'(XLEN);
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (md.flush_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          result_d = final_result;
          rd_out_d = rd_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = ~md.flush_i;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
`ifdef MULDIV_SIGNED_EN
      if (state_q == ST_IDLE && stall) begin
        neg_q     <= neg_d;
        neg_rem_q <= neg_rem_d;
      end
`endif
    end
  end

  assign md.stall_o     = stall;
  assign md.done_o      = done;
  assign md.reg_write_o = done;
  assign md.result_o    = result_q;
  assign md.rd_addr_o   = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  exp_t sb_q[$];

  ex_muldiv_unit_if #(.XLEN(32)) md_if ();

  ex_muldiv_unit #(
    .XLEN  (32),
    .CNT_W (6)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .md    (md_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic, independent of the iterative datapath.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0]        up;
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb;
    bit                 sgn;
`ifdef MULDIV_SIGNED_EN
    sgn = op[2];
`else
    sgn = 1'b0;
`endif
    sa = a;
    sb = b;
    if (!op[1]) begin
      if (sgn) begin
        sp = 64'(sa) * 64'(sb);
        up = sp;
      end else begin
        up = {32'b0, a} * {32'b0, b};
      end
      return op[0] ? up[63:32] : up[31:0];
    end
    if (b == 32'h0) return op[0] ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? 32'h0 : a;
      return op[0] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[0] ? (a % b) : (a / b);
  endfunction

  // Launch one op, follow it to completion and check stall count, pulse and result.
  // hold keeps start_i high and scrambles operands while busy and in the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold);
    int   stalls;
    int   cyc;
    bit   seen;
    exp_t e;
    @(negedge clk);
    sb_q.push_back('{res: model(op, a, b), rd: rd});
    md_if.start_i   = 1'b1;
    md_if.op_i      = op;
    md_if.rs_data_i = a;
    md_if.rt_data_i = b;
    md_if.rd_addr_i = rd;
    #1;
    stalls = md_if.stall_o ? 1 : 0;
    seen   = 1'b0;
    cyc    = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        md_if.rs_data_i = $urandom;
        md_if.rt_data_i = $urandom;
        md_if.rd_addr_i = ~rd;
      end else begin
        md_if.start_i = 1'b0;
      end
      #1;
      if (md_if.done_o) begin
        seen = 1'b1;
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_empty: done_o with no expected result queued");
        end else begin
          n_pass++;
          e = sb_q.pop_front();
          n_checks++;
          if (md_if.result_o !== e.res)
            $display("FAIL result op=%0h a=%h b=%h: got %h want %h", op, a, b, md_if.result_o,
                     e.res);
          else n_pass++;
          n_checks++;
          if (md_if.rd_addr_o !== e.rd)
            $display("FAIL rd_addr: got %0d want %0d", md_if.rd_addr_o, e.rd);
          else n_pass++;
        end
        n_checks++;
        if (md_if.reg_write_o !== 1'b1)
          $display("FAIL reg_write_in_done: got %b want 1", md_if.reg_write_o);
        else n_pass++;
        n_checks++;
        if (md_if.stall_o !== 1'b0)
          $display("FAIL stall_in_done: got %b want 0", md_if.stall_o);
        else n_pass++;
      end else if (md_if.stall_o) begin
        stalls++;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL done_timeout: got no done_o want done_o within 100 cycles");
    else n_pass++;
    n_checks++;
    if (stalls != 33) $display("FAIL stall_cycles: got %0d want 33", stalls);
    else n_pass++;
    @(negedge clk);
    md_if.start_i = 1'b0;
    #1;
    n_checks++;
    if (md_if.done_o !== 1'b0 || md_if.stall_o !== 1'b0)
      $display("FAIL after_done: got done=%b stall=%b want 0 0", md_if.done_o, md_if.stall_o);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({md_if.stall_o, md_if.done_o, md_if.reg_write_o, md_if.rd_addr_o, md_if.result_o} !== '0)
      $display("FAIL reset_outputs: got stall=%b done=%b we=%b rd=%0d res=%h want all 0",
               md_if.stall_o, md_if.done_o, md_if.reg_write_o, md_if.rd_addr_o, md_if.result_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    run_op(3'b000, 32'd7, 32'd6, 5'd5, 1'b0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0);
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);
    run_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8, 1'b0);
  endtask

  task automatic test_div();
    run_op(3'b010, 32'd100, 32'd7, 5'd9, 1'b0);
    run_op(3'b011, 32'd100, 32'd7, 5'd10, 1'b0);
    run_op(3'b010, 32'd5, 32'd0, 5'd11, 1'b0);
    run_op(3'b011, 32'd5, 32'd0, 5'd12, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd1, 5'd13, 1'b0);
  endtask

  task automatic test_flush();
    int dones;
    // Flush during BUSY cycle 10.
    @(negedge clk);
    md_if.start_i = 1'b1;
    md_if.op_i = 3'b000;
    md_if.rs_data_i = 32'd3;
    md_if.rt_data_i = 32'd4;
    md_if.rd_addr_i = 5'd14;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      md_if.start_i = 1'b0;
    end
    md_if.flush_i = 1'b1;
    #1;
    n_checks++;
    if (md_if.done_o !== 1'b0 || md_if.stall_o !== 1'b1)
      $display("FAIL flush_busy: got done=%b stall=%b want 0 1", md_if.done_o, md_if.stall_o);
    else n_pass++;
    @(negedge clk);
    md_if.flush_i = 1'b0;
    #1;
    n_checks++;
    if (md_if.stall_o !== 1'b0) $display("FAIL flush_stall_next: got %b want 0", md_if.stall_o);
    else n_pass++;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (md_if.done_o) dones++;
    end
    n_checks++;
    if (dones != 0) $display("FAIL flush_no_done: got %0d pulses want 0", dones);
    else n_pass++;

    // Flush in the DONE cycle suppresses the pulse.
    @(negedge clk);
    md_if.start_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      md_if.start_i = 1'b0;
    end
    @(negedge clk);
    md_if.flush_i = 1'b1;
    #1;
    n_checks++;
    if (md_if.done_o !== 1'b0 || md_if.reg_write_o !== 1'b0 || md_if.stall_o !== 1'b0)
      $display("FAIL flush_done: got done=%b we=%b stall=%b want 0 0 0", md_if.done_o,
               md_if.reg_write_o, md_if.stall_o);
    else n_pass++;
    @(negedge clk);
    md_if.flush_i = 1'b0;

    // Flush together with start in IDLE: no launch.
    @(negedge clk);
    md_if.start_i = 1'b1;
    md_if.flush_i = 1'b1;
    #1;
    n_checks++;
    if (md_if.stall_o !== 1'b0) $display("FAIL flush_idle_stall: got %b want 0", md_if.stall_o);
    else n_pass++;
    @(negedge clk);
    md_if.start_i = 1'b0;
    md_if.flush_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (md_if.done_o || md_if.stall_o) dones++;
    end
    n_checks++;
    if (dones != 0) $display("FAIL flush_idle_launch: got %0d active cycles want 0", dones);
    else n_pass++;
    run_op(3'b000, 32'd11, 32'd13, 5'd15, 1'b0);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    md_if.start_i = 1'b1;
    md_if.op_i = 3'b011;
    md_if.rs_data_i = 32'd1000;
    md_if.rt_data_i = 32'd3;
    md_if.rd_addr_i = 5'd16;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      md_if.start_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({md_if.stall_o, md_if.done_o, md_if.reg_write_o, md_if.rd_addr_o, md_if.result_o} !== '0)
      $display("FAIL mid_reset: got stall=%b done=%b we=%b rd=%0d res=%h want all 0",
               md_if.stall_o, md_if.done_o, md_if.reg_write_o, md_if.rd_addr_o, md_if.result_o);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (md_if.done_o || md_if.stall_o) begin
        n_checks++;
        $display("FAIL reset_residual: got activity at cycle %0d want idle", i);
        break;
      end
    end
    run_op(3'b011, 32'd1000, 32'd3, 5'd17, 1'b0);
  endtask

  task automatic test_signed();
`ifdef MULDIV_SIGNED_EN
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd18, 1'b0);
    run_op(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd19, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 1'b0);
    run_op(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 1'b0);
    run_op(3'b101, 32'hFFFF_FFFD, 32'd5, 5'd22, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd0, 5'd23, 1'b0);
    run_op(3'b111, 32'hFFFF_FFF9, 32'd0, 5'd24, 1'b0);
`else
    // Sign bit must be ignored in the unsigned build.
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd18, 1'b0);
    run_op(3'b101, 32'hFFFF_FFFD, 32'd5, 5'd22, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    run_op(3'b000, 32'd9, 32'd9, 5'd25, 1'b1);
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i == 3) ? 32'h0 : ($urandom >> (i * 3));
      run_op(3'($urandom_range(0, 7)), a, b, 5'($urandom), 1'b0);
    end
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    md_if.start_i = 1'b0;
    md_if.op_i = '0;
    md_if.rs_data_i = '0;
    md_if.rt_data_i = '0;
    md_if.rd_addr_i = '0;
    md_if.flush_i = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_mid_reset();
    test_signed();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage. It consumes operands and the destination register straight from the ID/EX pipeline register outputs.
- It asserts a stall back to the IF/ID and ID/EX registers while an operation runs.
- On completion it presents the result and destination register to the EX/MEM path for one cycle.
- It is the consumer (EX-side reader) of ID/EX decode fields, and provides the missing stall/flush feedback.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  ID/EX holds a valid mul/div instruction.
- op_i  in  3  [1:0]: 00 MUL (low word), 01 MULH (high word), 10 DIV, 11 REM; [2]: signed.
- rs_data_i  in  XLEN  operand A (forwarded RS data).
- rt_data_i  in  XLEN  operand B (forwarded RT data).
- rd_addr_i  in  5  destination register.
- flush_i  in  1  abort current operation (branch/exception flush).
- stall_o  out  1  hold IF/ID and ID/EX this cycle.
- done_o  out  1  result valid, single-cycle pulse.
- result_o  out  XLEN  result.
- rd_addr_o  out  5  destination accompanying result.
- reg_write_o  out  1  equals done_o; write-enable to EX/MEM.

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE, counter 0, all internal registers 0. Outputs: done_o 0, result_o 0, rd_addr_o 0, reg_write_o 0, stall_o 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start_i=1 and flush_i=0: latch operands, op and rd_addr_i; counter := XLEN; go to BUSY.
  - stall_o = start_i & ~flush_i, combinational. This holds ID/EX in the launch cycle.
- BUSY:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements.
  - When counter reaches 1 and that step completes, go to DONE.
  - stall_o = 1 throughout.
  - Operand inputs are ignored while BUSY.
- DONE:
  - done_o = 1, reg_write_o = 1; result_o and rd_addr_o valid.
  - stall_o = 0, so the pipeline advances past the mul/div instruction.
  - Next state is IDLE. A start_i in the DONE cycle is ignored; ID/EX has not yet advanced to the next instruction.
- Latency: start accepted at edge N; done_o high in cycle N+XLEN+1 (N+33 for XLEN 32); stall_o high for XLEN+1 cycles.
- Arithmetic:
  - 2*XLEN-bit product register; MUL returns bits [XLEN-1:0], MULH returns bits [2*XLEN-1:XLEN].
  - DIV returns quotient, REM returns remainder.
  - Unsigned when op_i[2] = 0.
- Divide by zero: quotient = all ones (0xFFFFFFFF), remainder = dividend. Still takes full latency; no exception.
- flush_i:
  - In BUSY or DONE: next edge goes to IDLE; done_o and reg_write_o are forced to 0 combinationally in that cycle.
  - With start_i in IDLE: no launch.
- Mid-operation reset: immediate return to reset values; no residual done pulse.
- result_o and rd_addr_o hold their last values outside DONE. Consumers qualify them with done_o.

Optional Feature:
- Macro MULDIV_SIGNED_EN.
- Defined:
  - op_i[2]=1 selects signed arithmetic.
  - Operands are converted to magnitude at launch; result sign is fixed in DONE.
    - MULH: sign of A xor B over the 2*XLEN product.
    - DIV: quotient negated if signs differ.
    - REM: takes the dividend's sign.
  - Overflow case (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0.
  - Divide by zero: same as the unsigned case.
  - Latency unchanged.
- Undefined: op_i[2] is ignored; all operations are unsigned; sign logic is absent.

Decomposition:
- Shared package pipe_pkg:
  - op encodings MD_MUL, MD_MULH, MD_DIV, MD_REM.
  - MD_SIGNED bit index.
  - state typedef/encodings ST_IDLE, ST_BUSY, ST_DONE.
  - XLEN constant.
- One sub-module, muldiv_step: combinational single-iteration datapath (add-shift or subtract-shift with restore select).
- The top module owns the FSM, counter, operand/result registers and sign fix-up.

Test Plan:
- Unsigned MUL, 7 x 6, rd=5 -> stall_o high 33 cycles; done_o pulses once; result_o=42, rd_addr_o=5, reg_write_o=1.
- MULH 0xFFFFFFFF x 0xFFFFFFFF unsigned -> result_o=0xFFFFFFFE; MUL of the same -> 0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- flush_i asserted at BUSY cycle 10 -> no done_o; stall_o low the next cycle; a subsequent start completes correctly.
- rst_i low at BUSY cycle 20 -> all outputs 0 immediately; IDLE after release.
- With MULDIV_SIGNED_EN: DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
